// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : posit_pkg
//  Description : Shared widths, requester ids and payload types for the posit
//                normalization path (add/mul mantissa -> normalizer -> encode).
//  Contents    : POSIT_N / POSIT_W / POSIT_CW widths, req_id_t with REQ_ADD and
//                REQ_MUL, the S1 payload struct, the all-run count code.
//  Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

    localparam int POSIT_N  = 16;
    localparam int POSIT_W  = POSIT_N + 1;          // datapath width
    localparam int POSIT_CW = $clog2(POSIT_N) + 1;  // shift-count width

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_ADD = 1'b0;
    localparam req_id_t REQ_MUL = 1'b1;

    // Count code reported when every datapath bit equals the skip polarity.
    localparam logic [POSIT_CW-1:0] POSIT_CNT_ALL = '1;

    typedef struct packed {
        logic [POSIT_W-1:0] data;
        logic               ozb;
        req_id_t            tag;
    } s1_payload_t;

endpackage : posit_pkg
`default_nettype wire

// File: rtl/normalizer_16.sv
`default_nettype none
// ============================================================================
//  Module      : normalizer_16
//  Description : Combinational leading-run normalizer. Counts how many leading
//                bits of the 17-bit operand equal the skip polarity and shifts
//                them out (zero fill).
//  Ports       : i_in    [16:0] operand
//                i_ozb          run polarity to skip
//                o_r     [16:0] operand shifted left by the run length
//                o_count [4:0]  run length 0..16, or 31 when all bits match
//  Revision    : 1.0 - initial release
// ============================================================================
module normalizer_16
    import posit_pkg::*;
(
    input  logic [POSIT_W-1:0]  i_in,
    input  logic                i_ozb,
    output logic [POSIT_W-1:0]  o_r,
    output logic [POSIT_CW-1:0] o_count
);

    logic [POSIT_CW-1:0] w_run;
    logic                w_stop;

    // Walk from the MSB; the first bit that differs from ozb terminates the run.
    always_comb begin
        w_run  = '0;
        w_stop = 1'b0;
        for (int i = POSIT_W - 1; i >= 0; i--) begin
            if (!w_stop) begin
                if (i_in[i] == i_ozb) begin
                    w_run = w_run + POSIT_CW'(1);
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    // An operand that is entirely ozb never terminates: report the saturated
    // code and keep the remainder left after a full N-bit shift.
    always_comb begin
        if (!w_stop) begin
            o_count = POSIT_CNT_ALL;
            o_r     = i_in << POSIT_N;
        end else begin
            o_count = w_run;
            o_r     = i_in << w_run;
        end
    end

endmodule : normalizer_16
`default_nettype wire

// File: rtl/posit_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : posit_norm_arbiter
//  Description : Round-robin sharing of one normalizer_16 between the posit
//                adder (requester 0) and multiplier (requester 1). Two-stage
//                valid/ready pipeline: S1 holds the granted operand, S2 is the
//                output register. The requester id travels as the tag.
//  Ports       : clk, rst_n              clock, async active-low reset
//                i_flush                 synchronous pipeline clear
//                i_reqK_valid/in/ozb     requester K operand, K = 0,1
//                o_reqK_ready            requester K operand accepted
//                o_valid, i_ready        output handshake
//                o_r, o_count, o_tag     normalized value, shift count, id
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_norm_arbiter
    import posit_pkg::*;
#(
    parameter int N    = 16,
    parameter int TAGW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_req0_valid,
    input  logic [N:0]           i_req0_in,
    input  logic                 i_req0_ozb,
    output logic                 o_req0_ready,
    input  logic                 i_req1_valid,
    input  logic [N:0]           i_req1_in,
    input  logic                 i_req1_ozb,
    output logic                 o_req1_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [N:0]           o_r,
    output logic [$clog2(N):0]   o_count,
    output logic [TAGW-1:0]      o_tag
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    req_id_t             rr_last_q,  rr_last_d;
    logic                s1_valid_q, s1_valid_d;
    s1_payload_t         s1_q,       s1_d;
    logic                o_valid_q,  o_valid_d;
    logic [POSIT_W-1:0]  o_r_q,      o_r_d;
    logic [POSIT_CW-1:0] o_count_q,  o_count_d;
    req_id_t             o_tag_q,    o_tag_d;

    // ------------------------------------------------------------------------
    // Pipeline advance
    // ------------------------------------------------------------------------
    logic w_adv2;
    logic w_adv1;

    assign w_adv2 = !o_valid_q || i_ready;
    assign w_adv1 = !s1_valid_q || w_adv2;

    // ------------------------------------------------------------------------
    // Arbiter: a lone requester wins; a tie goes to the one not served last.
    // ------------------------------------------------------------------------
    logic    w_grant_vld;
    req_id_t w_grant_id;
    logic    w_ready0;
    logic    w_ready1;
    logic    w_acc0;
    logic    w_acc1;
    logic    w_acc;

    always_comb begin
        w_grant_vld = i_req0_valid || i_req1_valid;
        w_grant_id  = REQ_ADD;
        if (i_req0_valid && i_req1_valid) begin
            w_grant_id = ~rr_last_q;
        end else if (i_req1_valid) begin
            w_grant_id = REQ_MUL;
        end
    end

    // A ready is only raised towards a valid requester, so every asserted
    // ready is an accept; the visible grant never leaves an unserved request.
    assign w_ready0 = w_grant_vld && (w_grant_id == REQ_ADD) && w_adv1 && !i_flush;
    assign w_ready1 = w_grant_vld && (w_grant_id == REQ_MUL) && w_adv1 && !i_flush;

    assign w_acc0 = i_req0_valid && w_ready0;
    assign w_acc1 = i_req1_valid && w_ready1;
    assign w_acc  = w_acc0 || w_acc1;

    assign o_req0_ready = w_ready0;
    assign o_req1_ready = w_ready1;

    // ------------------------------------------------------------------------
    // Shared normalizer between S1 and S2
    // ------------------------------------------------------------------------
    logic [POSIT_W-1:0]  w_norm_r;
    logic [POSIT_CW-1:0] w_norm_count;

    normalizer_16 u_norm (
        .i_in    (s1_q.data),
        .i_ozb   (s1_q.ozb),
        .o_r     (w_norm_r),
        .o_count (w_norm_count)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        rr_last_d  = rr_last_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        o_valid_d  = o_valid_q;
        o_r_d      = o_r_q;
        o_count_d  = o_count_q;
        o_tag_d    = o_tag_q;

        // Readies are already gated by flush, so no accept can coincide with it.
        if (w_acc0) begin
            rr_last_d = REQ_ADD;
        end else if (w_acc1) begin
            rr_last_d = REQ_MUL;
        end

        if (i_flush) begin
            s1_valid_d = 1'b0;
        end else if (w_adv1) begin
            s1_valid_d = w_acc;
            if (w_acc) begin
                s1_d.tag  = w_grant_id;
                s1_d.data = (w_grant_id == REQ_MUL) ? i_req1_in  : i_req0_in;
                s1_d.ozb  = (w_grant_id == REQ_MUL) ? i_req1_ozb : i_req0_ozb;
            end
        end

        // S2 drains and refills in the same cycle, giving one result per clock.
        if (i_flush) begin
            o_valid_d = 1'b0;
        end else if (w_adv2) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_r_d     = w_norm_r;
                o_count_d = w_norm_count;
                o_tag_d   = s1_q.tag;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q  <= REQ_MUL;  // requester 0 wins the first tie
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            o_valid_q  <= 1'b0;
            o_r_q      <= '0;
            o_count_q  <= '0;
            o_tag_q    <= REQ_ADD;
        end else begin
            rr_last_q  <= rr_last_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            o_valid_q  <= o_valid_d;
            o_r_q      <= o_r_d;
            o_count_q  <= o_count_d;
            o_tag_q    <= o_tag_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_r     = o_r_q;
    assign o_count = o_count_q;
    assign o_tag   = TAGW'(o_tag_q);

endmodule : posit_norm_arbiter
`default_nettype wire

// File: tb/tb_posit_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_norm_arbiter
//  Description : Directed scoreboard bench for posit_norm_arbiter. Expected
//                results are queued in predicted completion order when the
//                operands are issued; a monitor pops and compares on every
//                output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_norm_arbiter;

    typedef struct packed {
        logic [16:0] in;
        logic        ozb;
    } op_t;

    typedef struct packed {
        logic        tag;
        logic [16:0] r;
        logic [4:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_req0_valid = 1'b0;
    logic [16:0] i_req0_in = '0;
    logic        i_req0_ozb = 1'b0;
    logic        o_req0_ready;
    logic        i_req1_valid = 1'b0;
    logic [16:0] i_req1_in = '0;
    logic        i_req1_ozb = 1'b0;
    logic        o_req1_ready;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [16:0] o_r;
    logic [4:0]  o_count;
    logic [0:0]  o_tag;

    posit_norm_arbiter #(.N(16), .TAGW(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (i_flush),
        .i_req0_valid (i_req0_valid),
        .i_req0_in    (i_req0_in),
        .i_req0_ozb   (i_req0_ozb),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_in    (i_req1_in),
        .i_req1_ozb   (i_req1_ozb),
        .o_req1_ready (o_req1_ready),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_r          (o_r),
        .o_count      (o_count),
        .o_tag        (o_tag)
    );

    always #5 clk = ~clk;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   acc0 = 1'b0;
    bit   acc1 = 1'b0;
    bit   nxt_ready = 1'b1;
    bit   nxt_flush = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Queue an operand for requester k without any expected result (flushed).
    task automatic push_op(input int k, input logic [16:0] in, input logic ozb);
        op_t o;
        o.in  = in;
        o.ozb = ozb;
        if (k == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    // Queue an operand and its expected result; call order = completion order.
    task automatic push(input int k, input logic [16:0] in, input logic ozb,
                        input logic [16:0] r, input logic [4:0] cnt);
        exp_t e;
        push_op(k, in, ozb);
        e.tag = (k == 1);
        e.r   = r;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    // One clock: update drives 2 ns after the rising edge, then return at the
    // falling edge with this cycle's accepts recorded.
    task automatic tick();
        @(posedge clk);
        #2;
        if (acc0) q0.delete(0);
        if (acc1) q1.delete(0);
        acc0 = 1'b0;
        acc1 = 1'b0;
        i_ready = nxt_ready;
        i_flush = nxt_flush;
        i_req0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin
            i_req0_in  = q0[0].in;
            i_req0_ozb = q0[0].ozb;
        end
        i_req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin
            i_req1_in  = q1[0].in;
            i_req1_ozb = q1[0].ozb;
        end
        @(negedge clk);
        acc0 = i_req0_valid && o_req0_ready;
        acc1 = i_req1_valid && o_req1_ready;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    // Asynchronous reset held for one cycle, asserted away from the clock edge.
    task automatic reset_pulse(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        chk({name, "_valid_async"}, o_valid, 0);
        chk({name, "_tag_async"}, o_tag, 0);
        q0.delete();
        q1.delete();
        sb.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: a result is consumed on o_valid & i_ready; flushed
    // outputs are treated as dropped.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready && !i_flush) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL result_extra: got tag=%0d r=%05h cnt=%0d, expected no result",
                         o_tag, o_r, o_count);
            end else begin
                if ({o_tag, o_r, o_count} !== {sb[0].tag, sb[0].r, sb[0].cnt}) begin
                    failures++;
                    $display("FAIL result: got tag=%0d r=%05h cnt=%0d, expected tag=%0d r=%05h cnt=%0d",
                             o_tag, o_r, o_count, sb[0].tag, sb[0].r, sb[0].cnt);
                end
                sb.delete(0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [22:0] frozen;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_r", o_r, 0);
        chk("rst_count", o_count, 0);
        chk("rst_tag", o_tag, 0);
        rst_n = 1'b1;

        // ---------------- single request, latency ----------------
        push(0, 17'h0_00F0, 1'b0, 17'h1_E000, 5'd9);
        tick();
        chk("single_ready0", o_req0_ready, 1);
        chk("single_ready1", o_req1_ready, 0);
        chk("single_valid_t0", o_valid, 0);
        tick();
        chk("single_valid_t1", o_valid, 0);
        tick();
        chk("single_valid_t2", o_valid, 1);
        tick();
        chk("single_valid_after", o_valid, 0);
        chk("single_drained", sb.size(), 0);

        // ---------------- alternation after reset ----------------
        reset_pulse("rst_c");
        push(0, 17'h0_00F0, 1'b0, 17'h1_E000, 5'd9);
        push(1, 17'h1_FFFF, 1'b1, 17'h1_0000, 5'd31);
        push(0, 17'h0_0001, 1'b0, 17'h1_0000, 5'd16);
        push(1, 17'h0_8000, 1'b1, 17'h0_8000, 5'd0);
        push(0, 17'h1_2345, 1'b1, 17'h0_468A, 5'd1);
        push(1, 17'h1_F0F0, 1'b1, 17'h0_1E00, 5'd5);
        push(0, 17'h0_0000, 1'b0, 17'h0_0000, 5'd31);
        push(1, 17'h0_0F00, 1'b0, 17'h1_E000, 5'd5);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("alt_ready0", o_req0_ready, (k % 2 == 0));
            chk("alt_ready1", o_req1_ready, (k % 2 == 1));
            if (k >= 2) chk("alt_full_rate", o_valid, 1);
        end
        drain("alt_drain");

        // ---------------- back-pressure stall ----------------
        push(0, 17'h0_1000, 1'b0, 17'h1_0000, 5'd4);
        push(1, 17'h1_C123, 1'b1, 17'h0_0918, 5'd3);
        push(0, 17'h0_0003, 1'b0, 17'h1_8000, 5'd15);
        push(1, 17'h0_0000, 1'b1, 17'h0_0000, 5'd0);
        push(0, 17'h1_FFFF, 1'b0, 17'h1_FFFF, 5'd0);
        push(1, 17'h1_FFFD, 1'b1, 17'h0_8000, 5'd15);
        tick();
        tick();
        nxt_ready = 1'b0;
        tick();
        chk("stall_valid_1", o_valid, 1);
        frozen = {o_tag, o_r, o_count};
        for (int s = 2; s <= 5; s++) begin
            tick();
            chk("stall_valid", o_valid, 1);
            chk("stall_frozen", {o_tag, o_r, o_count}, frozen);
            chk("stall_ready0", o_req0_ready, 0);
            chk("stall_ready1", o_req1_ready, 0);
        end
        nxt_ready = 1'b1;
        drain("stall_drain");

        // ---------------- flush with S1 and S2 full ----------------
        nxt_ready = 1'b0;
        push_op(0, 17'h0_0100, 1'b0);
        push_op(0, 17'h0_0200, 1'b0);
        push(0, 17'h0_4000, 1'b0, 17'h1_0000, 5'd2);
        tick();
        tick();
        tick();
        chk("flush_pre_valid", o_valid, 1);
        chk("flush_pre_ready0", o_req0_ready, 0);
        nxt_flush = 1'b1;
        nxt_ready = 1'b1;
        tick();
        chk("flush_ready0", o_req0_ready, 0);
        chk("flush_ready1", o_req1_ready, 0);
        nxt_flush = 1'b0;
        tick();
        chk("flush_valid_next", o_valid, 0);
        chk("flush_ready_after", o_req0_ready, 1);
        drain("flush_drain");

        // ---------------- reset mid-stream ----------------
        // Last accept was requester 0, so the first tie goes to requester 1.
        push(1, 17'h1_0001, 1'b1, 17'h0_0002, 5'd1);
        push(0, 17'h0_0010, 1'b0, 17'h1_0000, 5'd12);
        push(1, 17'h0_1234, 1'b1, 17'h0_1234, 5'd0);
        push(0, 17'h0_0000, 1'b0, 17'h0_0000, 5'd31);
        tick();
        tick();
        tick();
        chk("mid_valid_before", o_valid, 1);
        reset_pulse("rst_g");
        push(0, 17'h0_0F00, 1'b0, 17'h1_E000, 5'd5);
        push(1, 17'h1_8001, 1'b1, 17'h0_0004, 5'd2);
        tick();
        chk("post_rst_ready0", o_req0_ready, 1);
        chk("post_rst_ready1", o_req1_ready, 0);
        tick();
        chk("post_rst_ready1_next", o_req1_ready, 1);
        drain("post_rst_drain");

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_posit_norm_arbiter
`default_nettype wire
